seg7_scan: RTL and testbench

- Display stage downstream of the BCD decade counter chain in the timer design.
- Takes DIGITS packed BCD digits (each counter's o_value) and time-multiplexes them onto one common 7-segment bus with one-hot anode select.
- Snapshots all digits once per scan frame, so a digit cannot tear while a counter carries mid-frame.
- Registered outputs; drives board pins directly.

---
 rtl/seg7_scan.sv | 120 ++++++++++++
 tb/tb_seg7_scan.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed 7-segment scanner with per-frame digit snapshot
// Optional leading-zero blanking: define SEG7_LZB_EN.
module seg7_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   i_digits,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_blank,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_frame
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx, idx_n;
  logic [4*DIGITS-1:0] snap_dig, snap_dig_n;
  logic [DIGITS-1:0]   snap_dp, snap_dp_n;
  logic                active;
  logic                tick;
  logic                frame_start;
  logic [3:0]          cur_dig;
  logic                cur_dp;
  logic                slot_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  // Next-cycle view of index and snapshot; at frame start digit 0 reads the live inputs.
  always_comb begin
    tick        = (presc == PRE_MAX);
    idx_n       = idx;
    snap_dig_n  = snap_dig;
    snap_dp_n   = snap_dp;
    frame_start = 1'b0;
    if (tick) begin
      idx_n       = (idx == IDX_MAX) ? '0 : idx + IW'(1);
      frame_start = (idx_n == '0);
    end
    if (frame_start) begin
      snap_dig_n = i_digits;
      snap_dp_n  = i_dp;
    end
    cur_dig = snap_dig_n[4*idx_n +: 4];
    cur_dp  = snap_dp_n[idx_n];
  end

`ifdef SEG7_LZB_EN
  logic [IW-1:0] hi, hi_n;

  // Highest nonzero digit of the frame, fixed at frame start.
  always_comb begin
    hi_n = hi;
    if (frame_start) begin
      hi_n = '0;
      for (int k = 0; k < DIGITS; k++) begin
        if (i_digits[4*k +: 4] != 4'd0) hi_n = IW'(k);
      end
    end
    slot_blank = (idx_n > hi_n) && !cur_dp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hi <= '0;
    else        hi <= hi_n;
  end
`else
  assign slot_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      idx      <= IDX_MAX;
      snap_dig <= '0;
      snap_dp  <= '0;
      active   <= 1'b0;
      o_an     <= '1;
      o_seg    <= 7'h7F;
      o_dp     <= 1'b1;
      o_frame  <= 1'b0;
    end else begin
      presc    <= tick ? '0 : presc + PW'(1);
      idx      <= idx_n;
      snap_dig <= snap_dig_n;
      snap_dp  <= snap_dp_n;
      o_frame  <= frame_start;
      if (tick) begin
        active <= 1'b1;
        o_seg  <= ~seg_decode(cur_dig);
        o_dp   <= ~cur_dp;
      end
      // Anodes follow blank every cycle, so release takes effect without waiting for a tick.
      if (i_blank || !(active || tick) || slot_blank) o_an <= '1;
      else                                            o_an <= ~(DIGITS'(1) << idx_n);
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - randomized bench for seg7_scan against an edge-count model
module tb_seg7_scan;
  localparam int ND = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_digits;
  logic [3:0]  i_dp;
  logic        i_blank;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_frame;

  seg7_scan #(.DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .i_digits(i_digits), .i_dp(i_dp), .i_blank(i_blank),
    .o_seg(o_seg), .o_dp(o_dp), .o_an(o_an), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  end

  // Model: slot number derives from edges since reset; frame start each ND slots.
  int          e, cur_k, hi;
  logic [15:0] snap;
  logic [3:0]  sdp;
  logic        lit;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e = 0; cur_k = ND - 1; hi = 0; snap = '0; sdp = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_frame = 1'b0;
    end else begin
      e++;
      exp_frame = 1'b0;
      if (e % SD == 0) begin
        cur_k = (e / SD - 1) % ND;
        if (cur_k == 0) begin
          snap = i_digits; sdp = i_dp; hi = 0;
          for (int k = 0; k < ND; k++) if (snap[4*k +: 4] != 4'd0) hi = k;
        end
        exp_seg   = ~seg_tab[snap[4*cur_k +: 4]];
        exp_dp    = ~sdp[cur_k];
        exp_frame = (cur_k == 0);
      end
      lit = (e >= SD) && !i_blank;
`ifdef SEG7_LZB_EN
      if (cur_k > hi && !sdp[cur_k]) lit = 1'b0;
`endif
      exp_an = lit ? ~(4'b0001 << cur_k) : 4'hF;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_an", 32'(o_an), 32'(exp_an));
      chk("cyc_seg", 32'(o_seg), 32'(exp_seg));
      chk("cyc_dp", 32'(o_dp), 32'(exp_dp));
      chk("cyc_frame", 32'(o_frame), 32'(exp_frame));
    end
  end

  task automatic wait_an(input logic [3:0] v, input string nm);
    int n = 0;
    while (o_an !== v && n < 64) begin @(negedge clk); n++; end
    chk(nm, 32'(o_an), 32'(v));
  endtask

  task automatic wait_frame(input string nm);
    int n = 0;
    @(negedge clk);
    while (o_frame !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    chk(nm, 32'(o_frame), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; i_digits = 16'h1234; i_dp = 4'h0; i_blank = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(o_an), 32'hF);
    chk("rst_seg", 32'(o_seg), 32'h7F);
    chk("rst_dp", 32'(o_dp), 32'd1);
    chk("rst_frame", 32'(o_frame), 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_an", 32'(o_an), 32'hF);
    @(negedge clk);
    chk("first_an", 32'(o_an), 32'hE);
    chk("first_frame", 32'(o_frame), 32'd1);
    chk("first_seg", 32'(o_seg), 32'h19);
    @(negedge clk);
    chk("frame_pulse", 32'(o_frame), 32'd0);
    repeat (3) @(negedge clk);
    chk("slot1_an", 32'(o_an), 32'hD);
    chk("slot1_seg", 32'(o_seg), 32'h30);
    repeat (4) @(negedge clk);
    chk("slot2_seg", 32'(o_seg), 32'h24);
    repeat (4) @(negedge clk);
    chk("slot3_an", 32'(o_an), 32'h7);
    chk("slot3_seg", 32'(o_seg), 32'h79);
    repeat (4) @(negedge clk);
    chk("frame16", 32'(o_frame), 32'd1);

    // Mid-frame change must not tear the current frame.
    wait_an(4'hD, "tear_sync");
    i_digits = 16'h5678;
    repeat (4) @(negedge clk);
    chk("tear_seg2", 32'(o_seg), 32'h24);
    repeat (4) @(negedge clk);
    chk("tear_seg3", 32'(o_seg), 32'h79);
    repeat (4) @(negedge clk);
    chk("new_seg0", 32'(o_seg), 32'h00);

    i_digits = 16'h00F0; i_dp = 4'b0010;
    wait_frame("inv_frame");
    wait_an(4'hD, "inv_sync");
    chk("inv_seg", 32'(o_seg), 32'h3F);
    chk("inv_dp", 32'(o_dp), 32'd0);
    repeat (4) @(negedge clk);
    chk("inv_dp2", 32'(o_dp), 32'd1);

    i_digits = 16'h0007; i_dp = 4'h0;
    wait_frame("lzb_frame");
    chk("lzb_seg0", 32'(o_seg), 32'h78);
    repeat (4) @(negedge clk);
`ifdef SEG7_LZB_EN
    chk("lzb_an1", 32'(o_an), 32'hF);
`else
    chk("lzb_an1", 32'(o_an), 32'hD);
`endif
    chk("lzb_seg1", 32'(o_seg), 32'h40);

    i_digits = 16'h4321;
    repeat (6) @(negedge clk);
    i_blank = 1'b1;
    @(negedge clk);
    chk("blank_an", 32'(o_an), 32'hF);
    repeat (9) @(negedge clk);
    i_blank = 1'b0;
    repeat (5) @(negedge clk);

    // Asynchronous reset in mid-scan.
    #1 rst_n = 1'b0;
    #1;
    chk("arst_an", 32'(o_an), 32'hF);
    chk("arst_seg", 32'(o_seg), 32'h7F);
    chk("arst_dp", 32'(o_dp), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_hold", 32'(o_an), 32'hF);
    @(negedge clk);
    chk("arst_first", 32'(o_an), 32'hE);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) i_digits = 16'($urandom);
      if ($urandom_range(7) == 0) i_dp = 4'($urandom);
      if ($urandom_range(15) == 0) i_blank = ~i_blank;
      if ($urandom_range(999) == 0) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
